tmds_rx_channel_decoder: RTL and testbench
==========================================

Name: tmds_rx_channel_decoder

Overview:
- Receive-side counterpart of the DVI/TMDS transmit path. One instance per TMDS channel (R, G or B).
- Takes the 10-bit parallel word from the channel deserializer and recovers word alignment by requesting bitslips.
- Decodes TMDS data words to 8-bit pixel data, and control tokens to C0/C1 and DE.
- Sits between the per-channel deserializer and the RGB/sync reconstruction and lane-deskew logic of the DVI RX top.

Parameters:
- LOCK_TOKENS, 8: consecutive control tokens required to declare alignment.
- SEARCH_WINDOW, 4096: cycles allowed without a qualifying token run before a bitslip (SEARCH) or loss of lock (LOCKED).
- BITSLIP_WAIT, 16: cycles idled after a bitslip pulse so the deserializer output can settle.

Ports:
- I_rgb_clk  in  1  pixel clock; all logic on rising edge.
- I_rst_n  in  1  asynchronous reset, active low.
- I_tmds_word  in  10  deserialized word; bit 9 is q_out[9] of the TMDS encoding, bit 0 is the first bit transmitted.
- O_bitslip  out  1  one-cycle pulse requesting a 1-bit word rotation from the deserializer.
- O_aligned  out  1  channel is word-aligned.
- O_de  out  1  recovered data enable.
- O_c  out  2  recovered control bits {C1,C0}.
- O_data  out  8  decoded pixel byte.

Behaviour:
- Reset (async assert, sync release): O_bitslip=0, O_aligned=0, O_de=0, O_c=2'b00, O_data=8'h00. FSM enters SEARCH and all counters clear.
- Stage 1: I_tmds_word is registered to w1.
- Token detect on w1 (combinational):
  - 10'b1101010100 -> 00
  - 10'b0010101011 -> 01
  - 10'b0101010100 -> 10
  - 10'b1010101011 -> 11
  - is_tok=1 for any of the four, else 0.
- Data decode on w1:
  - q = w1[9] ? ~w1[7:0] : w1[7:0]
  - d[0] = q[0]
  - for i=1..7: d[i] = w1[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1])
- Stage 2 outputs (registered; total latency 2 cycles from I_tmds_word to outputs):
  - O_de = O_aligned_next & ~is_tok.
  - O_data = d when O_de_next, else 8'h00.
  - O_c updates only when is_tok and O_aligned_next; otherwise it holds its value.
  - While not aligned: O_de=0, O_data=0, O_c holds.
- Counters:
  - tok_run (saturates at LOCK_TOKENS): increments on is_tok, clears on a non-token word.
  - win: free-running cycle count; clears whenever tok_run reaches LOCK_TOKENS.
- FSM states SEARCH, SLIP, WAIT, LOCKED:
  - SEARCH -> LOCKED when tok_run reaches LOCK_TOKENS. O_aligned rises in the same stage-2 cycle as the decode of that word, i.e. 2 cycles after the LOCK_TOKENS-th consecutive token enters.
  - SEARCH -> SLIP when win reaches SEARCH_WINDOW-1 first. If both conditions hit in the same cycle, lock wins.
  - SLIP: O_bitslip=1 for exactly one cycle -> WAIT.
  - WAIT: count BITSLIP_WAIT cycles, ignoring input; then -> SEARCH with tok_run=0 and win=0.
  - LOCKED: win clears on every completed token run. If win reaches SEARCH_WINDOW-1 -> SEARCH, O_aligned falls next cycle, and no bitslip is issued. Non-token words while LOCKED never break lock on their own.
- Bitslip pulses repeat indefinitely while misaligned: one pulse per SEARCH_WINDOW+BITSLIP_WAIT+1 cycles. There is no limit on retries.
- Counter widths are $clog2(param+1). Counters do not wrap: tok_run saturates and win is reset by FSM transitions.
- Reset asserted in any state (including mid-WAIT or the SLIP cycle) aborts immediately to reset values, and O_bitslip drops asynchronously.

Test Plan:
1. Reset, then drive 10'h000 constantly -> all outputs 0. First O_bitslip pulse at cycle SEARCH_WINDOW after reset release; next pulse exactly SEARCH_WINDOW+BITSLIP_WAIT+1 cycles later.
2. Drive 8× 10'b1101010100, then 10'h100, then 10'h2FF -> O_aligned=1 two cycles after the 8th token with O_c=00, O_de=0. Then O_de=1 with O_data=8'h00, then O_data=8'hFE. No O_bitslip pulse occurs.
3. Drive 7 tokens, 1 data word, then 8 tokens -> O_aligned rises only 2 cycles after the final 8th token, not earlier.
4. Locked link with a token run every 1000 cycles -> O_aligned stays 1. Stop tokens (data only) -> O_aligned falls SEARCH_WINDOW cycles after the last completed run; O_de=0 thereafter.
5. Drive token 10'b1010101011 while locked -> O_c=11, O_de=0. The following data word leaves O_c at 11.
6. Assert I_rst_n=0 two cycles into WAIT, release, feed a valid token stream -> clean restart from SEARCH. O_aligned sets after 8 tokens with no extra bitslip.

Source files
------------

// File: rtl/tmds_rx_channel_decoder.sv
// TMDS receive channel decoder: word alignment search and 10b -> 8b decode for one TMDS lane.
//
// Alignment is found by watching for a run of LOCK_TOKENS consecutive control tokens. Without
// such a run inside SEARCH_WINDOW cycles the decoder pulses O_bitslip so the deserializer rotates
// its word boundary. It then idles BITSLIP_WAIT cycles and searches again. Once locked, lock is
// only dropped when no completed token run is seen for SEARCH_WINDOW cycles. No bitslip is
// issued when lock is lost this way.
//
// Ports:
//   I_rgb_clk    pixel clock, rising edge
//   I_rst_n      asynchronous active-low reset
//   I_tmds_word  deserialized 10-bit word (bit 0 first on the wire)
//   O_bitslip    one-cycle request for a 1-bit word rotation
//   O_aligned    lane is word-aligned
//   O_de         recovered data enable
//   O_c          recovered control bits {C1,C0}
//   O_data       decoded pixel byte
// Latency from I_tmds_word to O_aligned/O_de/O_c/O_data is 2 cycles.
module tmds_rx_channel_decoder #(
  parameter int unsigned LOCK_TOKENS   = 8,
  parameter int unsigned SEARCH_WINDOW = 4096,
  parameter int unsigned BITSLIP_WAIT  = 16
) (
  input  logic       I_rgb_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_tmds_word,
  output logic       O_bitslip,
  output logic       O_aligned,
  output logic       O_de,
  output logic [1:0] O_c,
  output logic [7:0] O_data
);

  localparam int unsigned TokW  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned WinW  = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned WaitW = $clog2(BITSLIP_WAIT + 1);

  localparam logic [TokW-1:0]  TokFull = TokW'(LOCK_TOKENS);
  localparam logic [WinW-1:0]  WinLast = WinW'(SEARCH_WINDOW - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(BITSLIP_WAIT - 1);

  typedef enum logic [1:0] {StSearch, StSlip, StWait, StLocked} state_e;

  state_e           state_q, state_d;
  logic [9:0]       w1_q;
  logic [TokW-1:0]  tok_run_q, tok_run_d, tok_run_nx;
  logic [WinW-1:0]  win_q, win_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic       is_tok;
  logic [1:0] tok_c;
  logic [7:0] q, d, q_x;
  logic       run_done;
  logic       aligned_nx, de_nx;
  logic [1:0] c_nx;
  logic [7:0] data_nx;

  // Stage 1 input register.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      w1_q <= '0;
    end else begin
      w1_q <= I_tmds_word;
    end
  end

  // Control token detection.
  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (w1_q)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  // Data decode: undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  always_comb begin
    q      = w1_q[9] ? ~w1_q[7:0] : w1_q[7:0];
    q_x    = '0;
    q_x[7:1] = q[7:1] ^ q[6:0];
    d      = '0;
    d[0]   = q[0];
    d[7:1] = w1_q[8] ? q_x[7:1] : ~q_x[7:1];
  end

  // Alignment FSM and counters.
  always_comb begin
    state_d   = state_q;
    tok_run_d = tok_run_q;
    win_d     = win_q;
    wait_d    = wait_q;

    if (!is_tok) begin
      tok_run_nx = '0;
    end else if (tok_run_q == TokFull) begin
      tok_run_nx = tok_run_q;
    end else begin
      tok_run_nx = tok_run_q + 1'b1;
    end
    run_done = (tok_run_nx == TokFull);

    unique case (state_q)
      StSearch: begin
        tok_run_d = tok_run_nx;
        // A completed run takes priority over an expiring window.
        if (run_done) begin
          state_d = StLocked;
          win_d   = '0;
        end else if (win_q == WinLast) begin
          state_d = StSlip;
          win_d   = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      StSlip: begin
        state_d   = StWait;
        tok_run_d = '0;
        win_d     = '0;
        wait_d    = '0;
      end
      StWait: begin
        // Deserializer output is still settling; input is ignored.
        tok_run_d = '0;
        win_d     = '0;
        if (wait_q == WaitLast) begin
          state_d = StSearch;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StLocked: begin
        tok_run_d = tok_run_nx;
        if (run_done) begin
          win_d = '0;
        end else if (win_q == WinLast) begin
          state_d = StSearch;
          win_d   = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      default: begin
        state_d   = StSearch;
        tok_run_d = '0;
        win_d     = '0;
        wait_d    = '0;
      end
    endcase

    // Outputs follow the post-transition state so lock shows with the word that completed it.
    aligned_nx = (state_d == StLocked);
    de_nx      = aligned_nx & ~is_tok;
    data_nx    = de_nx ? d : 8'h00;
    c_nx       = (is_tok && aligned_nx) ? tok_c : O_c;
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= StSearch;
      tok_run_q <= '0;
      win_q     <= '0;
      wait_q    <= '0;
      O_aligned <= 1'b0;
      O_de      <= 1'b0;
      O_c       <= 2'b00;
      O_data    <= 8'h00;
    end else begin
      state_q   <= state_d;
      tok_run_q <= tok_run_d;
      win_q     <= win_d;
      wait_q    <= wait_d;
      O_aligned <= aligned_nx;
      O_de      <= de_nx;
      O_c       <= c_nx;
      O_data    <= data_nx;
    end
  end

  // Decoded from state so it drops as soon as reset asserts.
  assign O_bitslip = (state_q == StSlip);

endmodule

// File: tb/tb_tmds_rx_channel_decoder.sv
module tb_tmds_rx_channel_decoder;

  localparam int LT = 8;
  localparam int SW = 64;
  localparam int BW = 8;

  logic       clk;
  logic       rst_n;
  logic [9:0] tmds;
  logic       bitslip, aligned, de;
  logic [1:0] c;
  logic [7:0] data;

  tmds_rx_channel_decoder #(
    .LOCK_TOKENS  (LT),
    .SEARCH_WINDOW(SW),
    .BITSLIP_WAIT (BW)
  ) dut (
    .I_rgb_clk  (clk),
    .I_rst_n    (rst_n),
    .I_tmds_word(tmds),
    .O_bitslip  (bitslip),
    .O_aligned  (aligned),
    .O_de       (de),
    .O_c        (c),
    .O_data     (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       bitslip;
    logic       aligned;
    logic       de;
    logic [1:0] c;
    logic [7:0] data;
  } obs_t;

  obs_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   armed   = 1'b0;

  logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // Reference model: one step per word reaching the decode stage.
  int         m_run, m_age, m_slip_left;
  bit         m_lock;
  logic [1:0] m_c;

  task automatic m_reset();
    m_run = 0; m_age = 0; m_slip_left = 0; m_lock = 0; m_c = 2'b00;
  endtask

  function automatic bit tok_lookup(input logic [9:0] w, output logic [1:0] code);
    code = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (tok_tab[i] == w) begin
        code = 2'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] r;
    int qi, qp;
    qp = 0;
    for (int i = 0; i < 8; i++) begin
      qi = (w[i] ^ w[9]) ? 1 : 0;
      if (i == 0) r[i] = qi[0];
      else if (w[8]) r[i] = (qi != qp);
      else r[i] = (qi == qp);
      qp = qi;
    end
    return r;
  endfunction

  task automatic model_step(input logic [9:0] w);
    obs_t       e;
    logic [1:0] code;
    bit         tok;
    tok = tok_lookup(w, code);
    e   = '0;
    if (m_slip_left > 0) begin
      m_slip_left--;
      m_run = 0;
      m_age = 0;
    end else begin
      m_run = tok ? ((m_run + 1 > LT) ? LT : m_run + 1) : 0;
      if (m_run == LT) begin
        m_lock = 1;
        m_age  = 0;
      end else if (m_age == SW - 1) begin
        m_age = 0;
        if (m_lock) begin
          m_lock = 0;
        end else begin
          m_slip_left = BW + 1;
          e.bitslip   = 1'b1;
        end
      end else begin
        m_age++;
      end
      if (m_lock && tok) m_c = code;
      e.aligned = m_lock;
      e.de      = m_lock && !tok;
      e.data    = e.de ? ref_decode(w) : 8'h00;
    end
    e.c = m_c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, got, want, $time);
  endtask

  // Monitor: one expected entry per clock edge while out of reset.
  initial begin
    bit   live;
    obs_t e, g;
    forever begin
      @(posedge clk);
      live = armed && rst_n;
      @(negedge clk);
      if (live && rst_n) begin
        g = {bitslip, aligned, de, c, data};
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_empty: got %0h, required a queued entry at %0t", g, $time);
        end else begin
          e = exp_q.pop_front();
          check("outputs{bs,al,de,c,data}", 32'(g), 32'(e));
        end
      end
    end
  end

  task automatic drive(input logic [9:0] w);
    @(posedge clk);
    #1;
    tmds = w;
    model_step(w);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {27'd0, bitslip, aligned, de, c, data}, 32'd0);
    exp_q.delete();
    m_reset();
  endtask

  task automatic release_reset(input logic [9:0] first);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tmds  = first;
    armed = 1'b1;
    model_step(10'h000);  // power-on content of the input register
    model_step(first);
  endtask

  task automatic tokens(input int n, input logic [9:0] w);
    for (int i = 0; i < n; i++) drive(w);
  endtask

  task automatic wait_bitslip();
    bit found;
    found = 0;
    for (int i = 0; i < 4 * (SW + BW); i++) begin
      drive(10'h000);
      if (bitslip === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL bitslip_timeout: got no pulse, required one within %0d cycles", 4 * (SW + BW));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    tmds  = 10'h000;
    m_reset();
    #3;

    // Zeros: no lock, periodic bitslip.
    reset_now();
    release_reset(10'h000);
    tokens(2 * (SW + BW + 1) + 20, 10'h000);

    // Lock on 8 tokens, then two data words (00 then FE).
    tokens(LT, 10'b1101010100);
    drive(10'h100);
    drive(10'h2FF);
    tokens(5, 10'h0AA);

    // Broken run, then a full run.
    reset_now();
    release_reset(10'h000);
    tokens(LT - 1, 10'b0010101011);
    drive(10'h155);
    tokens(LT, 10'b0010101011);
    tokens(4, 10'h1F0);

    // Periodic runs keep lock; then only data until lock is lost.
    for (int r = 0; r < 8; r++) begin
      tokens(LT, tok_tab[$urandom_range(0, 3)]);
      for (int i = 0; i < 32; i++) drive(10'($urandom_range(0, 1023)));
    end
    for (int i = 0; i < SW + 20; i++) drive(10'($urandom_range(0, 1023)));

    // Control token C=11 while locked, then data keeps C.
    tokens(LT, 10'b1101010100);
    drive(10'b1010101011);
    drive(10'h1C3);
    drive(10'h0E7);

    // Randomized bursts of tokens and data.
    for (int b = 0; b < 120; b++) begin
      if ($urandom_range(0, 9) < 4) begin
        tokens(int'($urandom_range(1, 12)), tok_tab[$urandom_range(0, 3)]);
      end else begin
        int len;
        len = int'($urandom_range(1, 60));
        for (int i = 0; i < len; i++) drive(10'($urandom_range(0, 1023)));
      end
    end

    // Reset during the bitslip cycle, and again two cycles into the wait.
    reset_now();
    release_reset(10'h000);
    wait_bitslip();
    reset_now();
    release_reset(10'h000);
    wait_bitslip();
    drive(10'h000);
    drive(10'h000);
    reset_now();
    release_reset(10'b0101010100);
    tokens(LT + 4, 10'b0101010100);
    for (int i = 0; i < 40; i++) drive(10'($urandom_range(0, 1023)));

    drive(10'h000);
    drive(10'h000);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
